mux_ser_param: RTL and testbench
================================

Name: mux_ser_param

Overview:
- Parametrised successor of the TX-side source selector in the AES verify-platform data IP.
- Selects between a CPU word path and a wide cipher-block path, then drives a WORD_W-wide TX FIFO write port.
- Wide blocks are captured from a show-ahead source FIFO, popped immediately on capture, and serialised into NUM_WORDS words.
- Serialisation order, word width and words-per-block are configurable; blocks sent are counted.

Parameters:
WORD_W, 32, TX word width in bits.
NUM_WORDS, 4, words per block; legal range >= 2. Block width BLK_W = WORD_W*NUM_WORDS, derived internally.
MSB_FIRST, 1, 1 = most-significant word sent first; 0 = least-significant word first.
CNT_W, 16, width of the sent-block counter.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
sel  in  1  1 = CPU path, 0 = block path.
cpu_wr_tx_data  in  WORD_W  CPU write word.
cpu_wr_tx_require  in  1  CPU write strobe.
data_data  in  BLK_W  head of the show-ahead source FIFO; valid while data_empty=0.
data_require  out  1  source FIFO pop; one-cycle pulse per captured block.
data_empty  in  1  source FIFO empty.
tx_data  out  WORD_W  TX FIFO write data.
tx_require  out  1  TX FIFO write strobe; a word is accepted on any cycle with tx_require=1.
full  in  1  TX FIFO full.
busy  out  1  1 while a block is held in the shift register (state SEND).
blk_cnt  out  CNT_W  number of fully sent blocks; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, shreg=0, word_cnt=0, blk_cnt=0. Resulting outputs: tx_data=0, tx_require=0, data_require=0, busy=0. Reset mid-block discards the partial block; no further words of it are written.
- All outputs are combinational from registered state plus the inputs listed below. No output is registered separately.
- States:
  - IDLE: outputs 0. Next state is CPU if sel=1, else WAIT.
  - CPU: tx_data=cpu_wr_tx_data; tx_require=cpu_wr_tx_require & ~full. Stays in CPU while sel=1; goes to IDLE when sel=0. CPU words written while full=1 are dropped, not queued.
  - WAIT: tx_require=0.
    - If sel=1: next state IDLE.
    - Else if data_empty=0: shreg<=data_data, data_require=1 (combinational, same cycle), word_cnt<=0, next state SEND.
    - Capture does not depend on full.
  - SEND: busy=1; tx_data=word(word_cnt); tx_require=~full. sel is ignored until the block completes.
    - full=1: hold. word_cnt and shreg are unchanged; tx_data is stable.
    - full=0 and word_cnt<NUM_WORDS-1: word_cnt<=word_cnt+1.
    - full=0 and word_cnt=NUM_WORDS-1 (last word accepted): blk_cnt<=blk_cnt+1. Then:
      - If sel=0 and data_empty=0: back-to-back case. Capture the next block (shreg<=data_data, data_require=1 same cycle, word_cnt<=0) and stay in SEND.
      - Else if sel=1: next state IDLE.
      - Else: next state WAIT.
- word(k):
  - MSB_FIRST=1: shreg[BLK_W-1-k*WORD_W -: WORD_W].
  - MSB_FIRST=0: shreg[k*WORD_W +: WORD_W].
- word_cnt width is clog2(NUM_WORDS). blk_cnt wraps from 2^CNT_W-1 to 0 without saturating.
- Latency: first word is presented one cycle after a capture cycle. Back-to-back throughput is NUM_WORDS cycles per block when full=0.
- data_require is never asserted when data_empty=1 and never asserted outside a capture cycle.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset then release with sel=0, data_empty=1 -> state WAIT, all outputs 0, blk_cnt=0 indefinitely.
- sel=1, cpu_wr_tx_require=1, cpu_wr_tx_data=0xA5A5_0001 -> the cycle after IDLE: tx_data=0xA5A5_0001, tx_require=1. With full=1 -> tx_require=0.
- Defaults, data_data=0x00112233_44556677_8899AABB_CCDDEEFF, single block, full=0:
  - Capture cycle: data_require=1 for exactly 1 cycle.
  - Next 4 cycles: tx_data=0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with tx_require=1.
  - Then blk_cnt=1 and state WAIT.
- Same block with full=1 for 3 cycles while word 1 (0x44556677) is presented, and sel=1 raised in the same window -> tx_data holds 0x44556677 with tx_require=0. All 4 words still complete in order, then state IDLE, then CPU.
- Two queued blocks, full=0 -> 8 consecutive tx_require=1 cycles. data_require pulses on the capture cycle and on the cycle of the 4th word. blk_cnt=2.
- MSB_FIRST=0, NUM_WORDS=3, WORD_W=8, CNT_W=2, data_data=0xC3B2A1 sent 5 times:
  - Each block emits 0xA1, 0xB2, 0xC3.
  - blk_cnt sequence is 1, 2, 3, 0, 1.
  - Reset asserted mid-block -> that block's remaining words are never written.

Source files
------------

// File: rtl/mux_ser_param.sv
// mux_ser_param: TX-side source selector. Chooses between a CPU word path
// and a wide cipher-block path. Blocks are taken from a show-ahead source
// FIFO, popped on the capture cycle, and sent as NUM_WORDS words to a
// WORD_W-wide TX FIFO write port. Completed blocks are counted.
module mux_ser_param #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 4,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sel,
  input  logic [WORD_W-1:0]           cpu_wr_tx_data,
  input  logic                        cpu_wr_tx_require,
  input  logic [WORD_W*NUM_WORDS-1:0] data_data,
  output logic                        data_require,
  input  logic                        data_empty,
  output logic [WORD_W-1:0]           tx_data,
  output logic                        tx_require,
  input  logic                        full,
  output logic                        busy,
  output logic [CNT_W-1:0]            blk_cnt
);

  localparam int BLK_W = WORD_W * NUM_WORDS;
  localparam int CW    = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                             state;
  logic [BLK_W-1:0]                   shreg;
  logic [CW-1:0]                      word_cnt;

  // Word view of the shift register; index 0 is the least-significant word.
  logic [NUM_WORDS-1:0][WORD_W-1:0]   words;
  logic [CW-1:0]                      word_idx;
  logic                               last_word;
  logic                               accept;
  logic                               block_done;
  logic                               capture;

  assign words = shreg;

  // MSB-first order walks the word view from the top down.
  assign word_idx   = (MSB_FIRST != 0) ? (LAST_IDX - word_cnt) : word_cnt;
  assign last_word  = (word_cnt == LAST_IDX);
  assign accept     = (state == S_SEND) && !full;
  assign block_done = accept && last_word;

  // A block is captured from WAIT, or back-to-back as the last word leaves.
  assign capture = !sel && !data_empty &&
                   ((state == S_WAIT) || block_done);

  assign data_require = capture;
  assign busy         = (state == S_SEND);

  // Output mux: CPU pass-through or the current word of the held block.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    tx_data    = '0;
    tx_require = 1'b0;
    case (state)
      S_CPU: begin
        tx_data    = cpu_wr_tx_data;
        tx_require = cpu_wr_tx_require & ~full;
      end
      S_SEND: begin
        tx_data    = words[word_idx];
        tx_require = ~full;
      end
      default: ;
    endcase
  end

  // State, shift register, word index and block counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      word_cnt <= '0;
      blk_cnt  <= '0;
    end else begin
      if (capture) begin
        shreg    <= data_data;
        word_cnt <= '0;
      end else if (accept && !last_word) begin
        word_cnt <= word_cnt + CW'(1);
      end

      if (block_done) blk_cnt <= blk_cnt + CNT_W'(1);

      case (state)
        S_IDLE: state <= sel ? S_CPU : S_WAIT;
        S_CPU:  if (!sel) state <= S_IDLE;
        S_WAIT: begin
          if (sel)              state <= S_IDLE;
          else if (!data_empty) state <= S_SEND;
        end
        S_SEND: begin
          // sel is only honoured once the whole block has gone out.
          if (block_done && !capture) state <= sel ? S_IDLE : S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_ser_param.sv
// tb_mux_ser_param: scoreboard bench for two configurations of
// mux_ser_param (defaults, and an 8-bit x 3-word LSB-first variant).
module tb_mux_ser_param;

  localparam int AW = 32, AN = 4, AC = 16;
  localparam int BW = 8,  BN = 3, BC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A signals (default parameters)
  logic            a_sel = 0, a_cpu_req = 0, a_full = 0, a_data_empty = 1;
  logic [AW-1:0]   a_cpu_data = '0;
  logic [AW*AN-1:0] a_data = '0;
  logic            a_data_require, a_tx_require, a_busy;
  logic [AW-1:0]   a_tx_data;
  logic [AC-1:0]   a_blk_cnt;

  // Instance B signals (WORD_W=8, NUM_WORDS=3, LSB first, CNT_W=2)
  logic            b_sel = 0, b_cpu_req = 0, b_full = 0, b_data_empty = 1;
  logic [BW-1:0]   b_cpu_data = '0;
  logic [BW*BN-1:0] b_data = '0;
  logic            b_data_require, b_tx_require, b_busy;
  logic [BW-1:0]   b_tx_data;
  logic [BC-1:0]   b_blk_cnt;

  mux_ser_param u_a (
    .clk(clk), .rst(rst), .sel(a_sel),
    .cpu_wr_tx_data(a_cpu_data), .cpu_wr_tx_require(a_cpu_req),
    .data_data(a_data), .data_require(a_data_require), .data_empty(a_data_empty),
    .tx_data(a_tx_data), .tx_require(a_tx_require), .full(a_full),
    .busy(a_busy), .blk_cnt(a_blk_cnt)
  );

  mux_ser_param #(.WORD_W(BW), .NUM_WORDS(BN), .MSB_FIRST(0), .CNT_W(BC)) u_b (
    .clk(clk), .rst(rst), .sel(b_sel),
    .cpu_wr_tx_data(b_cpu_data), .cpu_wr_tx_require(b_cpu_req),
    .data_data(b_data), .data_require(b_data_require), .data_empty(b_data_empty),
    .tx_data(b_tx_data), .tx_require(b_tx_require), .full(b_full),
    .busy(b_busy), .blk_cnt(b_blk_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Source FIFO contents and expected TX word streams
  logic [AW*AN-1:0] a_src[$];
  logic [BW*BN-1:0] b_src[$];
  logic [AW-1:0]    a_exp[$];
  logic [BW-1:0]    b_exp[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    a_data_empty = (a_src.size() == 0);
    a_data       = a_data_empty ? '0 : a_src[0];
    b_data_empty = (b_src.size() == 0);
    b_data       = b_data_empty ? '0 : b_src[0];
  endfunction

  // Model: MSB-first split of a block into its words.
  task automatic push_a(input logic [AW*AN-1:0] blk);
    a_src.push_back(blk);
    for (int k = 0; k < AN; k++) a_exp.push_back(blk[AW*(AN-1-k) +: AW]);
    refresh();
    #1;
  endtask

  // Model: LSB-first split of a block into its words.
  task automatic push_b(input logic [BW*BN-1:0] blk);
    b_src.push_back(blk);
    for (int k = 0; k < BN; k++) b_exp.push_back(blk[BW*k +: BW]);
    refresh();
    #1;
  endtask

  // One clock: pop the source FIFOs on their pop strobes, settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (a_data_require && a_src.size() > 0) void'(a_src.pop_front());
    if (b_data_require && b_src.size() > 0) void'(b_src.pop_front());
    #1;
    refresh();
  endtask

  // Monitor A: word order, block count, pop legality, first-word latency.
  logic [AC-1:0] a_exp_blk = '0;
  int            a_words   = 0;
  logic          a_prev_cap = 0;
  always @(negedge clk) begin
    check("a_blk_cnt", a_blk_cnt, a_exp_blk);
    if (a_data_require && a_data_empty) check("a_pop_when_empty", a_data_require, 1'b0);
    if (a_prev_cap && !rst) check("a_first_word_latency", {a_busy, a_tx_require}, {1'b1, ~a_full});
    if (rst) begin
      a_exp.delete();
      a_words   = 0;
      a_exp_blk = '0;
    end else if (a_tx_require) begin
      if (a_exp.size() == 0) check("a_unexpected_word", a_tx_data, 'x);
      else check("a_word", a_tx_data, a_exp.pop_front());
      if (a_busy) begin
        a_words++;
        if (a_words == AN) begin
          a_words = 0;
          a_exp_blk++;
        end
      end
    end
    a_prev_cap = a_data_require && !rst;
  end

  // Monitor B: same checks for the narrow LSB-first configuration.
  logic [BC-1:0] b_exp_blk = '0;
  int            b_words   = 0;
  logic          b_prev_cap = 0;
  always @(negedge clk) begin
    check("b_blk_cnt", b_blk_cnt, b_exp_blk);
    if (b_data_require && b_data_empty) check("b_pop_when_empty", b_data_require, 1'b0);
    if (b_prev_cap && !rst) check("b_first_word_latency", {b_busy, b_tx_require}, {1'b1, ~b_full});
    if (rst) begin
      b_exp.delete();
      b_words   = 0;
      b_exp_blk = '0;
    end else if (b_tx_require) begin
      if (b_exp.size() == 0) check("b_unexpected_word", b_tx_data, 'x);
      else check("b_word", b_tx_data, b_exp.pop_front());
      if (b_busy) begin
        b_words++;
        if (b_words == BN) begin
          b_words = 0;
          b_exp_blk++;
        end
      end
    end
    b_prev_cap = b_data_require && !rst;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [127:0] BLK0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int n, first, last, txc, drc, dr2;
    logic [AW-1:0] w0 [AN];
    for (int k = 0; k < AN; k++) w0[k] = BLK0[AW*(AN-1-k) +: AW];

    // Reset, then idle in WAIT with an empty source
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_tx_require", a_tx_require, 1'b0);
    check("idle_data_require", a_data_require, 1'b0);
    check("idle_busy", a_busy, 1'b0);
    check("idle_tx_data", a_tx_data, '0);
    check("idle_blk_cnt", a_blk_cnt, '0);

    // CPU path, then CPU write dropped while full
    a_sel = 1'b1;
    tick(); tick();
    a_cpu_data = 32'hA5A5_0001; a_cpu_req = 1'b1;
    a_exp.push_back(32'hA5A5_0001);
    #1;
    check("cpu_tx_require", a_tx_require, 1'b1);
    check("cpu_tx_data", a_tx_data, 32'hA5A5_0001);
    tick();
    a_full = 1'b1; #1;
    check("cpu_full_tx_require", a_tx_require, 1'b0);
    tick();
    a_cpu_req = 1'b0; a_full = 1'b0; a_sel = 1'b0;
    tick(); tick();

    // Single block, MSB first
    push_a(BLK0);
    check("single_capture_pulse", a_data_require, 1'b1);
    tick();
    check("single_pulse_ends", a_data_require, 1'b0);
    for (int k = 0; k < AN; k++) begin
      check("single_word", a_tx_data, w0[k]);
      check("single_tx_require", a_tx_require, 1'b1);
      tick();
    end
    check("single_done_busy", a_busy, 1'b0);
    check("single_blk_cnt", a_blk_cnt, 16'd1);

    // Hold word 1 under full for 3 cycles with sel raised, then finish to IDLE/CPU
    push_a(BLK0);
    tick(); tick();
    a_full = 1'b1; a_sel = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("hold_tx_data", a_tx_data, w0[1]);
      check("hold_tx_require", a_tx_require, 1'b0);
      check("hold_busy", a_busy, 1'b1);
      tick();
    end
    a_full = 1'b0;
    n = 0;
    while (a_busy && n < 10) begin tick(); n++; end
    check("hold_remaining_cycles", n, 3);
    check("hold_blk_cnt", a_blk_cnt, 16'd2);
    tick();
    a_cpu_data = 32'h0BAD_CAFE; a_cpu_req = 1'b1;
    a_exp.push_back(32'h0BAD_CAFE);
    #1;
    check("after_hold_cpu_tx_require", a_tx_require, 1'b1);
    tick();
    a_cpu_req = 1'b0; a_sel = 1'b0;
    tick(); tick();

    // Back-to-back blocks
    push_a({$urandom, $urandom, $urandom, $urandom});
    push_a({$urandom, $urandom, $urandom, $urandom});
    first = -1; last = -1; txc = 0; drc = 0; dr2 = -1;
    for (int i = 0; i < 12; i++) begin
      if (a_data_require) begin
        drc++;
        if (i > 0) dr2 = i;
      end
      if (a_tx_require) begin
        if (first < 0) first = i;
        last = i;
        txc++;
      end
      tick();
    end
    check("b2b_words", txc, 8);
    check("b2b_contiguous", last - first, 7);
    check("b2b_pulses", drc, 2);
    check("b2b_second_pulse_cycle", dr2, 4);
    check("b2b_blk_cnt", a_blk_cnt, 16'd4);

    // Random blocks with random back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0 && a_src.size() < 2)
        push_a({$urandom, $urandom, $urandom, $urandom});
      a_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    a_full = 1'b0;
    n = 0;
    while ((a_exp.size() != 0 || a_busy || !a_data_empty) && n < 400) begin tick(); n++; end
    check("a_drain_in_time", n < 400, 1'b1);

    // Narrow LSB-first config: 5 identical blocks, counter wraps at 4
    for (int i = 0; i < 5; i++) push_b(24'hC3B2A1);
    n = 0;
    while ((b_exp.size() != 0 || b_busy || !b_data_empty) && n < 100) begin tick(); n++; end
    check("b_drain_in_time", n < 100, 1'b1);
    check("b_blk_cnt_wrapped", b_blk_cnt, 2'd1);

    // Reset mid-block: remaining words must never appear
    push_b(24'($urandom));
    tick(); tick();
    b_full = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; b_full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("b_after_reset_tx_require", b_tx_require, 1'b0);
      check("b_after_reset_busy", b_busy, 1'b0);
      tick();
    end
    check("b_after_reset_blk_cnt", b_blk_cnt, 2'd0);

    check("a_exp_empty", a_exp.size(), 0);
    check("b_exp_empty", b_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
